// File: rtl/hue_seq_ctrl_if.sv
// Pixel-in / hue-out handshake bundle for hue_seq_ctrl.
// Defining HUE_FRAC_EN adds out_frac to the result side.
interface hue_seq_ctrl_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_r;
    logic [7:0]       in_g;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [8:0]       out_hue;
    logic [TAG_W-1:0] out_tag;
`ifdef HUE_FRAC_EN
    logic [7:0]       out_frac;
`endif

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_hue, out_tag
`ifdef HUE_FRAC_EN
        , output out_frac
`endif
    );

    modport master (
        output in_valid, in_r, in_g, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_hue, out_tag
`ifdef HUE_FRAC_EN
        , input out_frac
`endif
    );
endinterface

// File: rtl/hue_seq_ctrl.sv
// One-pixel-at-a-time RGB -> hue sequencer: max/min, reciprocal LUT, 8-step shift-add, wrap.
// Optional HUE_FRAC_EN macro keeps 8 fractional bits of hue through scale and wrap.
module hue_seq_ctrl #(
    parameter int TAG_W = 8,
    parameter int LUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hue_seq_ctrl_if.slave    pix,
    output logic [7:0]       lut_addr,
    input  logic [LUT_W-1:0] lut_data,
    output logic             busy
);

`ifdef HUE_FRAC_EN
    localparam int FRAC = 8;
`else
    localparam int FRAC = 0;
`endif
    localparam int PW   = LUT_W + 8;
    localparam int HW   = 11 + FRAC;
    localparam int OW   = 9 + FRAC;
    localparam int FULL = 360 * (1 << FRAC);

    typedef enum logic [2:0] {IDLE, PREP, MULT, SCALE, FIN, OUT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [7:0]       mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [1:0]       case_q, case_d;
    logic             dz_q, dz_d;
    logic [LUT_W-1:0] lut_q, lut_d;
    logic [PW-1:0]    p_q, p_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [HW-1:0]    m_q, m_d;
    logic [OW-1:0]    hue_q, hue_d;

    // M = (P*257 + half) >> shift, with x257 as (P<<8)+P
    function automatic logic [HW-1:0] f_scale(input logic [PW-1:0] p);
        logic [PW+8:0] acc;
        acc = {1'b0, p, 8'b0} + (PW+9)'(p) + ((PW+9)'(1) << (31 - FRAC));
        return HW'(acc >> (32 - FRAC));
    endfunction

    function automatic logic [OW-1:0] f_wrap(input logic [1:0] cs, input logic neg,
                                             input logic [HW-1:0] m, input logic dz);
        logic signed [HW-1:0] h;
        logic signed [HW-1:0] off;
        case (cs)
            2'd1:    off = $signed(HW'(120) << FRAC);
            2'd2:    off = $signed(HW'(240) << FRAC);
            default: off = '0;
        endcase
        h = neg ? (off - $signed(m)) : (off + $signed(m));
        if (h < 0)
            h = h + $signed(HW'(FULL));
        if (h == $signed(HW'(FULL)))
            h = '0;
        if (dz)
            h = '0;
        return OW'(h);
    endfunction

    logic [7:0]        mx, mn, dlt;
    logic [1:0]        cs;
    logic signed [8:0] num;
    logic [7:0]        num_abs;

    // Case select: ties on max resolve R > G > B
    always_comb begin
        cs  = 2'd0;
        mx  = r_q;
        num = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
        if (r_q >= g_q && r_q >= b_q) begin
            cs  = 2'd0;
            mx  = r_q;
            num = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
        end else if (g_q >= b_q) begin
            cs  = 2'd1;
            mx  = g_q;
            num = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
        end else begin
            cs  = 2'd2;
            mx  = b_q;
            num = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
        end
        mn = r_q;
        if (g_q < mn) mn = g_q;
        if (b_q < mn) mn = b_q;
        dlt     = mx - mn;
        num_abs = num[8] ? 8'(-num) : num[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            case_q  <= '0;
            dz_q    <= 1'b0;
            lut_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            hue_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            case_q  <= case_d;
            dz_q    <= dz_d;
            lut_q   <= lut_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            hue_q   <= hue_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        tag_d   = tag_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        case_d  = case_q;
        dz_d    = dz_q;
        lut_d   = lut_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        hue_d   = hue_q;
        case (state_q)
            IDLE: begin
                if (pix.in_valid) begin
                    r_d     = pix.in_r;
                    g_d     = pix.in_g;
                    b_d     = pix.in_b;
                    tag_d   = pix.in_tag;
                    state_d = PREP;
                end
            end
            PREP: begin
                case_d  = cs;
                neg_d   = num[8];
                mag_d   = num_abs;
                lut_d   = lut_data;
                dz_d    = (dlt == 8'd0);
                p_d     = '0;
                cnt_d   = '0;
                state_d = (dlt == 8'd0) ? FIN : MULT;
            end
            MULT: begin
                // LSB-first: bit cnt of |num| adds lut << cnt
                if (mag_q[cnt_q])
                    p_d = p_q + (PW'(lut_q) << cnt_q);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7)
                    state_d = SCALE;
            end
            SCALE: begin
                m_d     = f_scale(p_q);
                state_d = FIN;
            end
            FIN: begin
                hue_d   = f_wrap(case_q, neg_q, m_q, dz_q);
                state_d = OUT;
            end
            OUT: begin
                if (pix.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // D is a pure function of the held pixel, so it stays put outside PREP
    assign lut_addr      = dlt;
    assign busy          = (state_q != IDLE);
    assign pix.in_ready  = (state_q == IDLE);
    assign pix.out_valid = (state_q == OUT);
    assign pix.out_hue   = hue_q[OW-1:FRAC];
    assign pix.out_tag   = tag_q;
`ifdef HUE_FRAC_EN
    assign pix.out_frac  = hue_q[7:0];
`endif

endmodule
